// File: rtl/downscale_pkg.sv
// Shared types and elaboration-time helpers for the bilinear downscaler.
// Latency: none (package only).
// Backpressure: none (package only).
package downscale_pkg;

    typedef logic [7:0] pixel_t;

    localparam int DEF_FRAC_BITS = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Fixed-point source step per destination step, truncated toward zero.
    function automatic longint unsigned ratio(input int src, input int dst,
                                              input int frac = DEF_FRAC_BITS);
        longint unsigned num;
        num = longint'(src - 1) << frac;
        return num / longint'(dst - 1);
    endfunction

endpackage

// File: rtl/bilinear_lane.sv
// One bilinear interpolation lane: four neighbours and two weights to a pixel.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is captured.
// Ports: a/b = top-left/top-right, c/d = bottom-left/bottom-right neighbours,
//        xw/yw = fractional weights toward b/d and c/d, pix = saturated result.
module bilinear_lane
    import downscale_pkg::*;
#(
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  pixel_t               a,
    input  pixel_t               b,
    input  pixel_t               c,
    input  pixel_t               d,
    input  logic [FRAC_BITS-1:0] xw,
    input  logic [FRAC_BITS-1:0] yw,
    output pixel_t               pix
);

    // Horizontal sums peak at 255 * 2^F; the vertical sum adds another 2^F factor
    // plus the rounding constant, so 2F+10 bits leaves headroom.
    localparam int TW = FRAC_BITS + 9;
    localparam int SW = 2 * FRAC_BITS + 10;
    localparam int IW = SW - 2 * FRAC_BITS;

    localparam logic [FRAC_BITS:0] ONE = {1'b1, {FRAC_BITS{1'b0}}};
    localparam logic [SW-1:0]      RND = SW'(1) << (2 * FRAC_BITS - 1);

    logic [FRAC_BITS:0] w_xi;
    logic [FRAC_BITS:0] w_yi;
    logic [TW-1:0]      w_top;
    logic [TW-1:0]      w_bot;
    logic [SW-1:0]      w_sum;
    logic [IW-1:0]      w_int;

    assign w_xi = ONE - {1'b0, xw};
    assign w_yi = ONE - {1'b0, yw};

    // Both stages stay at full precision; rounding happens once at the end.
    assign w_top = TW'(a) * TW'(w_xi) + TW'(b) * TW'(xw);
    assign w_bot = TW'(c) * TW'(w_xi) + TW'(d) * TW'(xw);
    assign w_sum = SW'(w_top) * SW'(w_yi) + SW'(w_bot) * SW'(yw) + RND;

    assign w_int = IW'(w_sum >> (2 * FRAC_BITS));
    assign pix   = (w_int > IW'(255)) ? 8'hFF : w_int[7:0];

endmodule

// File: rtl/downscale_simd.sv
// Bilinear frame downscaler, N destination pixels written per clock.
// Latency: start at edge E -> writes on E+1..E+G, done pulse visible after E+G+1.
// Backpressure: none; start is ignored while busy, image_in must stay stable.
// Ports: clk, rst (async active-low), start, image_in[SRC_H][SRC_W],
//        done (one-cycle pulse), image_out[DST_H][DST_W] (registered).
module downscale_simd
    import downscale_pkg::*;
#(
    parameter int SRC_H     = 32,
    parameter int SRC_W     = 32,
    parameter int DST_H     = 16,
    parameter int DST_W     = 16,
    parameter int N         = 4,
    parameter int FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  pixel_t image_in  [SRC_H][SRC_W],
    output logic   done,
    output pixel_t image_out [DST_H][DST_W]
);

    localparam int XIW = $clog2(SRC_W);
    localparam int YIW = $clog2(SRC_H);
    localparam int XCW = XIW + FRAC_BITS;
    localparam int YCW = YIW + FRAC_BITS;
    localparam int DIW = $clog2(DST_W);
    localparam int RIW = $clog2(DST_H);
    // Column counter must hold col+k for the widest disabled lane.
    localparam int CW  = $clog2(DST_W + N) + 1;

    localparam logic [XCW-1:0] XR = XCW'(ratio(SRC_W, DST_W, FRAC_BITS));
    localparam logic [YCW-1:0] YR = YCW'(ratio(SRC_H, DST_H, FRAC_BITS));

    state_t          r_state;
    state_t          w_state_nxt;
    logic [RIW-1:0]  r_row;
    logic [CW-1:0]   r_col;
    logic            r_done;
    logic            w_run;
    logic            w_done_nxt;
    logic            w_col_wrap;
    logic            w_row_last;

    assign w_col_wrap = (r_col + CW'(N)) >= CW'(DST_W);
    assign w_row_last = (r_row == RIW'(DST_H - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_run = 1'b1;
                if (w_col_wrap && w_row_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------- counters and done ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row  <= '0;
            r_col  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            if (r_state == S_IDLE && start) begin
                r_row <= '0;
                r_col <= '0;
            end else if (w_run) begin
                if (w_col_wrap) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + RIW'(1);
                end else begin
                    r_col <= r_col + CW'(N);
                end
            end
        end
    end

    assign done = r_done;

    // ---------------- shared row coordinate ----------------
    logic [YCW-1:0]       w_ys;
    logic [YIW-1:0]       w_yl;
    logic [YIW-1:0]       w_yh;
    logic [FRAC_BITS-1:0] w_yw;

    assign w_ys = YCW'(r_row) * YR;
    assign w_yl = w_ys[YCW-1:FRAC_BITS];
    assign w_yw = w_ys[FRAC_BITS-1:0];
    assign w_yh = (w_yl == YIW'(SRC_H - 1)) ? w_yl : w_yl + YIW'(1);

    // ---------------- lanes ----------------
    logic [N-1:0]   w_en;
    logic [DIW-1:0] w_xc  [N];
    pixel_t         w_pix [N];

    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [CW-1:0]        w_ck;
        logic [XCW-1:0]       w_xs;
        logic [XIW-1:0]       w_xl;
        logic [XIW-1:0]       w_xh;
        logic [FRAC_BITS-1:0] w_xw;

        assign w_ck    = r_col + CW'(k);
        assign w_en[k] = w_run && (w_ck < CW'(DST_W));
        // Disabled lanes are clamped so neighbour reads stay inside the source.
        assign w_xc[k] = (w_ck < CW'(DST_W)) ? w_ck[DIW-1:0] : DIW'(DST_W - 1);

        assign w_xs = XCW'(w_xc[k]) * XR;
        assign w_xl = w_xs[XCW-1:FRAC_BITS];
        assign w_xw = w_xs[FRAC_BITS-1:0];
        assign w_xh = (w_xl == XIW'(SRC_W - 1)) ? w_xl : w_xl + XIW'(1);

        bilinear_lane #(
            .FRAC_BITS(FRAC_BITS)
        ) u_lane (
            .a   (image_in[w_yl][w_xl]),
            .b   (image_in[w_yl][w_xh]),
            .c   (image_in[w_yh][w_xl]),
            .d   (image_in[w_yh][w_xh]),
            .xw  (w_xw),
            .yw  (w_yw),
            .pix (w_pix[k])
        );
    end

    // ---------------- output array ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DST_H; i++) begin
                for (int j = 0; j < DST_W; j++) begin
                    image_out[i][j] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (w_en[k]) begin
                    image_out[r_row][w_xc[k]] <= w_pix[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_downscale_simd.sv
module tb_downscale_simd;
    import downscale_pkg::*;

    localparam int SH = 32;
    localparam int SW = 32;
    localparam int DH = 16;
    localparam int DW = 16;

    logic   clk;
    logic   rst;
    logic   start;
    logic   start3;
    logic   done;
    logic   done3;
    pixel_t img  [SH][SW];
    pixel_t out  [DH][DW];
    pixel_t out3 [DH][DW];

    int errors = 0;
    int checks = 0;

    downscale_simd #(
        .SRC_H(SH), .SRC_W(SW), .DST_H(DH), .DST_W(DW), .N(4), .FRAC_BITS(16)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .image_in(img),
        .done(done), .image_out(out)
    );

    downscale_simd #(
        .SRC_H(SH), .SRC_W(SW), .DST_H(DH), .DST_W(DW), .N(3), .FRAC_BITS(16)
    ) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .image_in(img),
        .done(done3), .image_out(out3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Real-valued bilinear reference with round-half-up.
    function automatic int model_px(int i, int j);
        real xs, ys, fx, fy, top, bot, v;
        int  xl, xh, yl, yh;
        xs = j * real'(SW - 1) / real'(DW - 1);
        ys = i * real'(SH - 1) / real'(DH - 1);
        xl = $rtoi(xs);
        yl = $rtoi(ys);
        xh = (xl + 1 > SW - 1) ? SW - 1 : xl + 1;
        yh = (yl + 1 > SH - 1) ? SH - 1 : yl + 1;
        fx = xs - xl;
        fy = ys - yl;
        top = img[yl][xl] * (1.0 - fx) + img[yl][xh] * fx;
        bot = img[yh][xl] * (1.0 - fx) + img[yh][xh] * fx;
        v = top * (1.0 - fy) + bot * fy;
        return $rtoi(v + 0.5);
    endfunction

    function automatic int count_off(bit use3);
        int bad, m, o;
        bad = 0;
        for (int i = 0; i < DH; i++) begin
            for (int j = 0; j < DW; j++) begin
                m = model_px(i, j);
                o = use3 ? int'(out3[i][j]) : int'(out[i][j]);
                if (o - m > 1 || m - o > 1) bad++;
            end
        end
        return bad;
    endfunction

    task automatic load_gradient();
        for (int i = 0; i < SH; i++)
            for (int j = 0; j < SW; j++)
                img[i][j] = 8'((4 * i + 2 * j) & 255);
    endtask

    // Pulses start on the chosen DUT and returns the edge index (after the
    // accepting edge) at which done is first seen, or -1 on timeout.
    task automatic run_frame(input bit use3, output int cyc);
        cyc = -1;
        @(posedge clk); #1;
        if (use3) start3 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start3 = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (use3 ? done3 : done) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int nz, nz3;
        rst = 1'b0; start = 1'b0; start3 = 1'b0;
        load_gradient();
        #12;
        nz = 0; nz3 = 0;
        for (int i = 0; i < DH; i++)
            for (int j = 0; j < DW; j++) begin
                if (out[i][j] !== 8'd0) nz++;
                if (out3[i][j] !== 8'd0) nz3++;
            end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (nz !== 0) begin errors++; $display("FAIL reset_out: nonzero=%0d expected 0", nz); end
        checks++; if (done3 !== 1'b0) begin errors++; $display("FAIL reset_done3: got %b expected 0", done3); end
        checks++; if (nz3 !== 0) begin errors++; $display("FAIL reset_out3: nonzero=%0d expected 0", nz3); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_gradient();
        int cyc, bad;
        load_gradient();
        run_frame(1'b0, cyc);
        checks++; if (cyc !== 65) begin errors++; $display("FAIL grad_cycles: got %0d expected 65", cyc); end
        checks++; if (out[0][0] !== 8'd0) begin errors++; $display("FAIL grad_00: got %0d expected 0", out[0][0]); end
        checks++; if (out[0][1] !== 8'd4) begin errors++; $display("FAIL grad_01: got %0d expected 4", out[0][1]); end
        checks++; if (out[15][15] !== 8'd186) begin errors++; $display("FAIL grad_1515: got %0d expected 186", out[15][15]); end
        bad = count_off(1'b0);
        checks++; if (bad !== 0) begin errors++; $display("FAIL grad_model: off_by_more_than_1=%0d expected 0", bad); end
    endtask

    task automatic test_constant();
        int cyc, bad;
        for (int i = 0; i < SH; i++)
            for (int j = 0; j < SW; j++)
                img[i][j] = 8'h80;
        run_frame(1'b0, cyc);
        checks++; if (cyc !== 65) begin errors++; $display("FAIL const_cycles: got %0d expected 65", cyc); end
        bad = 0;
        for (int i = 0; i < DH; i++)
            for (int j = 0; j < DW; j++)
                if (out[i][j] !== 8'd128) bad++;
        checks++; if (bad !== 0) begin errors++; $display("FAIL const_all128: wrong=%0d expected 0", bad); end
    endtask

    task automatic test_checker();
        int cyc, bad;
        for (int i = 0; i < SH; i++)
            for (int j = 0; j < SW; j++)
                img[i][j] = ((i + j) % 2 == 1) ? 8'hFF : 8'h00;
        run_frame(1'b0, cyc);
        checks++; if (cyc !== 65) begin errors++; $display("FAIL chk_cycles: got %0d expected 65", cyc); end
        bad = count_off(1'b0);
        checks++; if (bad !== 0) begin errors++; $display("FAIL chk_model: off_by_more_than_1=%0d expected 0", bad); end
    endtask

    // Exact done timing; a second start mid-frame must be ignored.
    task automatic test_cycle_count();
        int ones, at;
        load_gradient();
        ones = 0; at = -1;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (k == 10) start = 1'b1;
            if (k == 11) start = 1'b0;
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ones++;
                if (at < 0) at = k;
            end
        end
        checks++; if (at !== 65) begin errors++; $display("FAIL done_edge: got %0d expected 65", at); end
        checks++; if (ones !== 1) begin errors++; $display("FAIL done_pulses: got %0d expected 1", ones); end
    endtask

    task automatic test_partial_n3();
        int cyc, bad;
        load_gradient();
        run_frame(1'b1, cyc);
        checks++; if (cyc !== 97) begin errors++; $display("FAIL n3_cycles: got %0d expected 97", cyc); end
        checks++; if (out3[15][15] !== 8'd186) begin errors++; $display("FAIL n3_1515: got %0d expected 186", out3[15][15]); end
        checks++; if (out3[0][15] !== 8'd62) begin errors++; $display("FAIL n3_0015: got %0d expected 62", out3[0][15]); end
        bad = 0;
        for (int i = 0; i < DH; i++) begin
            if (int'(out3[i][15]) - model_px(i, 15) > 1 || model_px(i, 15) - int'(out3[i][15]) > 1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL n3_col15: off=%0d expected 0", bad); end
        bad = count_off(1'b1);
        checks++; if (bad !== 0) begin errors++; $display("FAIL n3_model: off=%0d expected 0", bad); end
    endtask

    task automatic test_reset_mid_run();
        int nz, pulses;
        // Clear outputs first so the partial frame is the only content.
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        load_gradient();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
        end
        checks++; if (out[0][1] !== 8'd4) begin errors++; $display("FAIL mid_partial: got %0d expected 4", out[0][1]); end
        #2 rst = 1'b0;
        #1;
        nz = 0;
        for (int i = 0; i < DH; i++)
            for (int j = 0; j < DW; j++)
                if (out[i][j] !== 8'd0) nz++;
        checks++; if (nz !== 0) begin errors++; $display("FAIL mid_out_cleared: nonzero=%0d expected 0", nz); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b expected 0", done); end
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            if (k == 3) rst = 1'b1;
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL mid_no_done: pulses=%0d expected 0", pulses); end
    endtask

    task automatic test_restart();
        int cyc, bad;
        run_frame(1'b0, cyc);
        checks++; if (cyc !== 65) begin errors++; $display("FAIL restart_cycles: got %0d expected 65", cyc); end
        checks++; if (out[0][1] !== 8'd4) begin errors++; $display("FAIL restart_01: got %0d expected 4", out[0][1]); end
        checks++; if (out[15][15] !== 8'd186) begin errors++; $display("FAIL restart_1515: got %0d expected 186", out[15][15]); end
        bad = count_off(1'b0);
        checks++; if (bad !== 0) begin errors++; $display("FAIL restart_model: off=%0d expected 0", bad); end
    endtask

    initial begin
        test_reset();
        test_gradient();
        test_constant();
        test_checker();
        test_cycle_count();
        test_partial_n3();
        test_reset_mid_run();
        test_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
